mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control FSM that sequences a shared-memory ARM datapath (single memory port for fetch and data) through fetch/decode/execute/writeback.
- Decodes Instr[31:12], holds NZCV and evaluates condition codes.
- Drives every datapath select and enable: PC, IR, register file, ALU, memory.
- Stalls on a memory-ready handshake.

Parameters:
- HAS_MEMREADY, 1, when 0 the MemReady input is ignored and treated as 1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset; asserted when 0
- Instr  in  20  IR bits [31:12]
- ALUFlags  in  4  NZCV from the ALU in the current cycle
- MemReady  in  1  memory completes the current access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register enable
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  0 = regfile A, 1 = PC
- ALUSrcB  out  2  00 = RD2, 01 = ExtImm, 10 = constant 4
- ImmSrc  out  2  passed through from Instr[27:26]
- RegSrc  out  2  [0] = branch (RA1 = R15), [1] = STR (RA2 = Rd)
- ALUControl  out  4  ALU operation code
- FlagsQ  out  4  architectural NZCV
- Illegal  out  1  sticky flag: undecodable instruction seen

Behaviour:
- Reset (reset==0): state=FETCH, FlagsQ=0, Illegal=0, cond_ex_q=0. All enables forced 0 while reset==0. Select outputs 0.
- States and transitions (Moore outputs, all decoded from the state register):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. IRWrite and PCWrite assert only when MemReady=1. Stay in FETCH while MemReady=0.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (R15 reads PC+8). Latch cond_ex_q = condcheck(Instr[31:28], FlagsQ). Next state by op=Instr[27:26]:
    - 00 with Instr[25]=0 -> EXECR; with Instr[25]=1 -> EXECI
    - 01 -> MEMADR
    - 10 -> BRANCH
    - 11 -> ILLEGAL
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. Both -> ALUWB. Flags write happens at the end of this cycle (rule below).
  - ALUWB: ResultSrc=00. RegWrite=cond_ex_q & ~noWrite. PCWrite instead when Rd(Instr[15:12])==15. -> FETCH.
  - MEMADR: ALUSrcB=01, ALUControl = ADD if U (Instr[23]) else SUB. -> MEMRD if L (Instr[20]), else MEMWR.
  - MEMRD: AdrSrc=1. Hold until MemReady -> MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=cond_ex_q. Rd==15 gives PCWrite instead. -> FETCH.
  - MEMWR: AdrSrc=1, RegSrc[1]=1, MemWrite=cond_ex_q. Hold until MemReady -> FETCH.
  - BRANCH: RegSrc[0]=1, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=cond_ex_q. -> FETCH.
  - ILLEGAL: set Illegal=1, no enables. -> FETCH.
- An instruction failing its condition still walks its states with every write suppressed.
- Data-processing command decode, Instr[24:21] -> ALUControl:
  - AND 0000 -> 0000
  - EOR 0001 -> 0100
  - SUB 0010 -> 0001
  - ADD 0100 -> 0000 with bit3 clear... use: ADD 0100 -> 0010
  - CMP 1010 -> 0001, noWrite, S forced to 1
  - ORR 1100 -> 0011
  - MOV 1101 -> 0101 (pass B)
  - Any other command -> ILLEGAL from DECODE.
- Flags: at the end of EXEC*, FlagsQ <= ALUFlags iff S (Instr[20]) & cond_ex_q. Logic ops update only N and Z; C and V are kept.
- Condition codes: all 15 ARM codes; 1111 is treated as never.
- Latency with MemReady=1:
  - DP 4 cycles, LDR 5, STR 4, B 3, illegal 3.
  - Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction returns to FETCH immediately. No partial write may occur after reset assertion.

Decomposition:
- Shared package mc_pkg holds:
  - state enum
  - ALUControl codes
  - op/cmd/cond localparams
  - ResultSrc/ALUSrcB encodings
- One sub-module, cond_check: combinational cond + NZCV -> CondEx.
- The FSM and decode stay in mc_controller.

Test Plan:
- ADD R2,R0,#5 (0xE2802005), MemReady=1 -> states FETCH, DECODE, EXECI, ALUWB. RegWrite=1 in cycle 4 only, ALUControl=0010, FlagsQ unchanged.
- SUBS/CMP R2,R2 (0xE1520002) with ALUFlags=0100 -> FlagsQ=0100, RegWrite never asserted. Then BEQ (0x0A000001) -> PCWrite=1 in BRANCH. Repeat with FlagsQ=0000 -> PCWrite=0, still 3 cycles.
- LDR R1,[R0,#4] (0xE5901004) with MemReady low 2 cycles in MEMRD -> 7 cycles total, AdrSrc=1 throughout MEMRD, RegWrite=1 with ResultSrc=01 in MEMWB.
- STR R1,[R0,#8] (0xE5801008) -> MemWrite=1, RegSrc=10 in MEMWR. MemReady held 0 in FETCH for 3 cycles -> IRWrite/PCWrite pulse once on the ready cycle.
- Instr=0xEC000000 -> ILLEGAL, Illegal=1 sticky across subsequent ADD. Drop reset to 0 -> Illegal=0, FETCH.
- Assert reset during MEMWR with MemReady=0 -> MemWrite drops the same cycle (asynchronous). After release, state=FETCH, FlagsQ=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StExecI,
        StAluWb,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StBranch,
        StIllegal
    } state_e;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluOrr = 4'b0011;
    localparam logic [3:0] AluEor = 4'b0100;
    localparam logic [3:0] AluMov = 4'b0101;

    localparam logic [1:0] OpDp     = 2'b00;
    localparam logic [1:0] OpMem    = 2'b01;
    localparam logic [1:0] OpBranch = 2'b10;
    localparam logic [1:0] OpUndef  = 2'b11;

    localparam logic [3:0] CmdAnd = 4'b0000;
    localparam logic [3:0] CmdEor = 4'b0001;
    localparam logic [3:0] CmdSub = 4'b0010;
    localparam logic [3:0] CmdAdd = 4'b0100;
    localparam logic [3:0] CmdCmp = 4'b1010;
    localparam logic [3:0] CmdOrr = 4'b1100;
    localparam logic [3:0] CmdMov = 4'b1101;

    localparam logic [3:0] CondEq = 4'b0000;
    localparam logic [3:0] CondNe = 4'b0001;
    localparam logic [3:0] CondCs = 4'b0010;
    localparam logic [3:0] CondCc = 4'b0011;
    localparam logic [3:0] CondMi = 4'b0100;
    localparam logic [3:0] CondPl = 4'b0101;
    localparam logic [3:0] CondVs = 4'b0110;
    localparam logic [3:0] CondVc = 4'b0111;
    localparam logic [3:0] CondHi = 4'b1000;
    localparam logic [3:0] CondLs = 4'b1001;
    localparam logic [3:0] CondGe = 4'b1010;
    localparam logic [3:0] CondLt = 4'b1011;
    localparam logic [3:0] CondGt = 4'b1100;
    localparam logic [3:0] CondLe = 4'b1101;
    localparam logic [3:0] CondAl = 4'b1110;
    localparam logic [3:0] CondNv = 4'b1111;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcBRd2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    typedef struct packed {
        logic       legal;
        logic [3:0] alu_ctl;
        logic       no_write;
        logic       logic_op;
    } dp_dec_t;

    // Logic ops leave C and V untouched when flags are written.
    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d = '{legal: 1'b1, alu_ctl: AluAdd, no_write: 1'b0, logic_op: 1'b0};
        case (cmd)
            CmdAnd: begin d.alu_ctl = AluAnd; d.logic_op = 1'b1; end
            CmdEor: begin d.alu_ctl = AluEor; d.logic_op = 1'b1; end
            CmdSub: d.alu_ctl = AluSub;
            CmdAdd: d.alu_ctl = AluAdd;
            CmdCmp: begin d.alu_ctl = AluSub; d.no_write = 1'b1; end
            CmdOrr: begin d.alu_ctl = AluOrr; d.logic_op = 1'b1; end
            CmdMov: begin d.alu_ctl = AluMov; d.logic_op = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: IR fields, ALU flags, memory handshake and all controls.
interface mc_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  FlagsQ;
    logic        Illegal;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegSrc, ALUControl, FlagsQ, Illegal
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, RegSrc, ALUControl, FlagsQ, Illegal
    );
endinterface

// File: rtl/cond_check.sv
// ARM condition-code evaluation against NZCV; code 1111 never passes.
module cond_check
    import mc_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       cond_ex_o
);

    logic n, z, c, v;
    assign {n, z, c, v} = flags_i;

    always_comb begin
        cond_ex_o = 1'b0;
        unique case (cond_i)
            CondEq: cond_ex_o = z;
            CondNe: cond_ex_o = ~z;
            CondCs: cond_ex_o = c;
            CondCc: cond_ex_o = ~c;
            CondMi: cond_ex_o = n;
            CondPl: cond_ex_o = ~n;
            CondVs: cond_ex_o = v;
            CondVc: cond_ex_o = ~v;
            CondHi: cond_ex_o = c & ~z;
            CondLs: cond_ex_o = ~c | z;
            CondGe: cond_ex_o = (n == v);
            CondLt: cond_ex_o = (n != v);
            CondGt: cond_ex_o = ~z & (n == v);
            CondLe: cond_ex_o = z | (n != v);
            CondAl: cond_ex_o = 1'b1;
            CondNv: cond_ex_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller for a shared-memory ARM datapath: fetch/decode/execute/writeback FSM,
// NZCV flag register and condition gating of every architectural write.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit HAS_MEMREADY = 1'b1
) (
    input logic  clk,
    input logic  reset,
    mc_if.master ctl_io
);

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;
    logic       illegal_q, illegal_d;

    logic [3:0] cond, cmd, rd;
    logic [1:0] op;
    logic       i_bit, s_bit, u_bit, l_bit;
    logic       mem_ready, cond_pass, s_eff;
    dp_dec_t    dp;

    // Instr holds IR[31:12], so IR bit k sits at Instr[k-12].
    assign cond  = ctl_io.Instr[19:16];
    assign op    = ctl_io.Instr[15:14];
    assign i_bit = ctl_io.Instr[13];
    assign cmd   = ctl_io.Instr[12:9];
    assign u_bit = ctl_io.Instr[11];
    assign s_bit = ctl_io.Instr[8];
    assign l_bit = ctl_io.Instr[8];
    assign rd    = ctl_io.Instr[3:0];

    logic unused_rn;
    assign unused_rn = ^ctl_io.Instr[7:4];

    assign mem_ready = HAS_MEMREADY ? ctl_io.MemReady : 1'b1;
    assign dp        = dp_decode(cmd);
    assign s_eff     = s_bit | dp.no_write;

    cond_check u_cond_check (
        .cond_i    (cond),
        .flags_i   (flags_q),
        .cond_ex_o (cond_pass)
    );

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                cond_ex_d = cond_pass;
                unique case (op)
                    OpDp:     state_d = !dp.legal ? StIllegal : (i_bit ? StExecI : StExecR);
                    OpMem:    state_d = StMemAdr;
                    OpBranch: state_d = StBranch;
                    OpUndef:  state_d = StIllegal;
                endcase
            end
            StExecR, StExecI: begin
                state_d = StAluWb;
                if (s_eff && cond_ex_q) begin
                    flags_d = dp.logic_op ? {ctl_io.ALUFlags[3:2], flags_q[1:0]} : ctl_io.ALUFlags;
                end
            end
            StAluWb:   state_d = StFetch;
            StMemAdr:  state_d = l_bit ? StMemRd : StMemWr;
            StMemRd:   if (mem_ready) state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   if (mem_ready) state_d = StFetch;
            StBranch:  state_d = StFetch;
            StIllegal: begin
                illegal_d = 1'b1;
                state_d   = StFetch;
            end
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
            illegal_q <= illegal_d;
        end
    end

    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] result_src, alu_src_b, imm_src, reg_src;
    logic [3:0] alu_ctl;
    logic       wb_en;

    assign wb_en = cond_ex_q & ~(state_q == StAluWb && dp.no_write);

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        result_src = ResAluOut;
        alu_src_b  = SrcBRd2;
        imm_src    = op;
        reg_src    = 2'b00;
        alu_ctl    = 4'b0000;
        case (state_q)
            StFetch: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBFour;
                alu_ctl    = AluAdd;
                result_src = ResAluResult;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            StDecode: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SrcBFour;
                alu_ctl    = AluAdd;
                result_src = ResAluResult;
            end
            StExecR: alu_ctl = dp.alu_ctl;
            StExecI: begin
                alu_src_b = SrcBImm;
                alu_ctl   = dp.alu_ctl;
            end
            StAluWb, StMemWb: begin
                result_src = (state_q == StMemWb) ? ResData : ResAluOut;
                if (rd == 4'hF) pc_write = wb_en;
                else            reg_write = wb_en;
            end
            StMemAdr: begin
                alu_src_b = SrcBImm;
                alu_ctl   = u_bit ? AluAdd : AluSub;
            end
            StMemRd: adr_src = 1'b1;
            StMemWr: begin
                adr_src   = 1'b1;
                reg_src   = 2'b10;
                mem_write = cond_ex_q;
            end
            StBranch: begin
                reg_src    = 2'b01;
                alu_src_b  = SrcBImm;
                alu_ctl    = AluAdd;
                result_src = ResAluResult;
                pc_write   = cond_ex_q;
            end
            default: ;
        endcase
        // Reset kills every strobe and select combinationally, not just at the next edge.
        if (!reset) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            result_src = 2'b00;
            alu_src_b  = 2'b00;
            imm_src    = 2'b00;
            reg_src    = 2'b00;
            alu_ctl    = 4'b0000;
        end
    end

    assign ctl_io.PCWrite    = pc_write;
    assign ctl_io.AdrSrc     = adr_src;
    assign ctl_io.MemWrite   = mem_write;
    assign ctl_io.IRWrite    = ir_write;
    assign ctl_io.RegWrite   = reg_write;
    assign ctl_io.ResultSrc  = result_src;
    assign ctl_io.ALUSrcA    = alu_src_a;
    assign ctl_io.ALUSrcB    = alu_src_b;
    assign ctl_io.ImmSrc     = imm_src;
    assign ctl_io.RegSrc     = reg_src;
    assign ctl_io.ALUControl = alu_ctl;
    assign ctl_io.FlagsQ     = flags_q;
    assign ctl_io.Illegal    = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected control words are queued by the
// stimulus and popped by a monitor that samples on the falling edge.
module tb_mc_controller;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mc_if bus();

    mc_controller #(
        .HAS_MEMREADY (1'b1)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ctl_io (bus)
    );

    localparam logic [19:0] IAdd  = 20'hE2802;  // ADD  R2,R0,#5
    localparam logic [19:0] ICmp  = 20'hE1520;  // CMP  R2,R2
    localparam logic [19:0] IBeq  = 20'h0A000;  // BEQ
    localparam logic [19:0] IAnds = 20'hE0110;  // ANDS R0,R1,R2
    localparam logic [19:0] ILdr  = 20'hE5901;  // LDR  R1,[R0,#4]
    localparam logic [19:0] IStr  = 20'hE5801;  // STR  R1,[R0,#8]
    localparam logic [19:0] IUnd  = 20'hEC000;

    typedef struct {
        string       name;
        logic [22:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_ev;

    // Field order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB
    //              ImmSrc RegSrc ALUControl FlagsQ Illegal
    logic [22:0] act_v;
    assign act_v = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                    bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc,
                    bus.ALUControl, bus.FlagsQ, bus.Illegal};

    function automatic logic [22:0] pk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic rw, input logic [1:0] rs,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [1:0] rgs,
                                       input logic [3:0] alu, input logic [3:0] fl,
                                       input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, rgs, alu, fl, ill};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (act_v !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %b required %b", e.name, act_v, e.v);
                end
            end
        end
    end

    task automatic cyc(input string name, input logic [19:0] instr, input logic [3:0] aluf,
                       input logic rdy, input logic [22:0] e);
        bus.Instr    = instr;
        bus.ALUFlags = aluf;
        bus.MemReady = rdy;
        sb_q.push_back('{name: name, v: e});
        @(posedge clk);
        #1;
    endtask

    logic [22:0] zero_v;

    initial begin : stim
        zero_v       = '0;
        bus.Instr    = IAdd;
        bus.ALUFlags = 4'hF;
        bus.MemReady = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset.idle", IAdd, 4'hF, 1'b1, zero_v);
        reset = 1'b1;

        // ADD imm, S=0: ALUFlags must not reach FlagsQ
        cyc("add.fetch",  IAdd, 4'hF, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'h0,0));
        cyc("add.decode", IAdd, 4'hF, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'h0,0));
        cyc("add.execi",  IAdd, 4'hF, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,4'b0010,4'h0,0));
        cyc("add.aluwb",  IAdd, 4'hF, 1'b1, pk(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,4'b0000,4'h0,0));

        // CMP sets Z, never writes a register
        cyc("cmp1.fetch",  ICmp, 4'b0100, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'h0,0));
        cyc("cmp1.decode", ICmp, 4'b0100, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'h0,0));
        cyc("cmp1.execr",  ICmp, 4'b0100, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0001,4'h0,0));
        cyc("cmp1.aluwb",  ICmp, 4'b0100, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,4'b0100,0));

        // BEQ taken
        cyc("beq1.fetch",  IBeq, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b10,2'b00,4'b0010,4'b0100,0));
        cyc("beq1.decode", IBeq, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b10,2'b00,4'b0010,4'b0100,0));
        cyc("beq1.branch", IBeq, 4'h0, 1'b1, pk(1,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,4'b0010,4'b0100,0));

        // CMP clears Z (sets C,V); BEQ then not taken but still three cycles
        cyc("cmp2.fetch",  ICmp, 4'b0011, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'b0100,0));
        cyc("cmp2.decode", ICmp, 4'b0011, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'b0100,0));
        cyc("cmp2.execr",  ICmp, 4'b0011, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0001,4'b0100,0));
        cyc("cmp2.aluwb",  ICmp, 4'b0011, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,4'b0011,0));
        cyc("beq2.fetch",  IBeq, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b10,2'b00,4'b0010,4'b0011,0));
        cyc("beq2.decode", IBeq, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b10,2'b00,4'b0010,4'b0011,0));
        cyc("beq2.branch", IBeq, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,0,2'b01,2'b10,2'b01,4'b0010,4'b0011,0));

        // ANDS: logic op updates N,Z only, C,V kept
        cyc("ands.fetch",  IAnds, 4'b1100, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'b0011,0));
        cyc("ands.decode", IAnds, 4'b1100, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'b0011,0));
        cyc("ands.execr",  IAnds, 4'b1100, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b00,2'b00,2'b00,4'b0000,4'b0011,0));
        cyc("ands.aluwb",  IAnds, 4'b1100, 1'b1, pk(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,4'b0000,4'b1111,0));

        // LDR with two wait cycles in MEMRD: seven cycles
        cyc("ldr.fetch",  ILdr, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'hF,0));
        cyc("ldr.decode", ILdr, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'hF,0));
        cyc("ldr.memadr", ILdr, 4'h0, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,4'b0010,4'hF,0));
        cyc("ldr.memrd0", ILdr, 4'h0, 1'b0, pk(0,1,0,0,0,2'b00,0,2'b00,2'b01,2'b00,4'b0000,4'hF,0));
        cyc("ldr.memrd1", ILdr, 4'h0, 1'b0, pk(0,1,0,0,0,2'b00,0,2'b00,2'b01,2'b00,4'b0000,4'hF,0));
        cyc("ldr.memrd2", ILdr, 4'h0, 1'b1, pk(0,1,0,0,0,2'b00,0,2'b00,2'b01,2'b00,4'b0000,4'hF,0));
        cyc("ldr.memwb",  ILdr, 4'h0, 1'b1, pk(0,0,0,0,1,2'b01,0,2'b00,2'b01,2'b00,4'b0000,4'hF,0));

        // STR with three stalled fetch cycles
        for (int i = 0; i < 3; i++) begin
            cyc("str.fetchwait", IStr, 4'h0, 1'b0,
                pk(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'hF,0));
        end
        cyc("str.fetch",  IStr, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'hF,0));
        cyc("str.decode", IStr, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'hF,0));
        cyc("str.memadr", IStr, 4'h0, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,4'b0010,4'hF,0));
        cyc("str.memwr",  IStr, 4'h0, 1'b1, pk(0,1,1,0,0,2'b00,0,2'b00,2'b01,2'b10,4'b0000,4'hF,0));

        // Undefined op, then Illegal stays set across an ADD
        cyc("und.fetch",   IUnd, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b11,2'b00,4'b0010,4'hF,0));
        cyc("und.decode",  IUnd, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b11,2'b00,4'b0010,4'hF,0));
        cyc("und.illegal", IUnd, 4'h0, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b00,2'b11,2'b00,4'b0000,4'hF,0));
        cyc("add2.fetch",  IAdd, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'hF,1));
        cyc("add2.decode", IAdd, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,4'b0010,4'hF,1));
        cyc("add2.execi",  IAdd, 4'h0, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b01,2'b00,2'b00,4'b0010,4'hF,1));
        cyc("add2.aluwb",  IAdd, 4'h0, 1'b1, pk(0,0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,4'b0000,4'hF,1));
        reset = 1'b0;
        cyc("reset2.idle", IAdd, 4'h0, 1'b1, zero_v);
        reset = 1'b1;

        // Reset lands in the middle of a stalled store
        cyc("str2.fetch",  IStr, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'h0,0));
        cyc("str2.decode", IStr, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'h0,0));
        cyc("str2.memadr", IStr, 4'h0, 1'b1, pk(0,0,0,0,0,2'b00,0,2'b01,2'b01,2'b00,4'b0010,4'h0,0));
        cyc("str2.memwr0", IStr, 4'h0, 1'b0, pk(0,1,1,0,0,2'b00,0,2'b00,2'b01,2'b10,4'b0000,4'h0,0));
        sb_q.push_back('{name: "str2.memwr1",
                         v: pk(0,1,1,0,0,2'b00,0,2'b00,2'b01,2'b10,4'b0000,4'h0,0)});
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        sb_q.push_back('{name: "str2.async_reset", v: zero_v});
        ->sample_ev;
        @(posedge clk);
        #1;
        cyc("reset3.hold", IStr, 4'h0, 1'b0, zero_v);
        reset = 1'b1;
        cyc("post.fetch",  IStr, 4'h0, 1'b1, pk(1,0,0,1,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'h0,0));
        cyc("post.decode", IStr, 4'h0, 1'b1, pk(0,0,0,0,0,2'b10,1,2'b10,2'b01,2'b00,4'b0010,4'h0,0));

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard.drain: got %0d pending entries required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
